// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download streamer and its helpers.
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    localparam logic [7:0] IOCTL_IDX_ROM = 8'd0;
    localparam logic [7:0] IOCTL_IDX_MOD = 8'd1;
    localparam logic [7:0] IOCTL_IDX_DIP = 8'd254;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_FINISH
    } stream_state_e;

    function automatic logic [7:0] chksum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/ioctl_streamer_if.sv
// Byte source handshake plus ioctl download bus, as seen by the streamer (master).
interface ioctl_streamer_if
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W
);
    logic              src_valid;
    logic [7:0]        src_data;
    logic              src_ready;
    logic              wr_ack;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;

    modport master (
        input  src_valid, src_data, wr_ack,
        output src_ready, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
    );

    modport slave (
        output src_valid, src_data, wr_ack,
        input  src_ready, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
    );
endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a req/ack toggle, with a change detector on the synced level.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_i,
    output logic level_o,
    output logic edge_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tog_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign edge_o  = s2_q ^ s3_q;
endmodule

// File: rtl/ioctl_streamer.sv
// Streams bytes from a valid/ready source onto the ioctl download bus, pacing on a toggle ack.
// Optional running byte checksum output enabled by IOCTL_STREAMER_CHKSUM_EN.
module ioctl_streamer
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W,
    parameter int GAP    = 2,
    parameter int ACK_TO = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        index_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    ioctl_streamer_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef IOCTL_STREAMER_CHKSUM_EN
    ,
    output logic [7:0]        chksum
`endif
);
    localparam logic [3:0]  GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TO - 1);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;
    logic              download_q, download_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              ack_seen_q, ack_seen_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
`ifdef IOCTL_STREAMER_CHKSUM_EN
    logic [7:0]        chksum_q, chksum_d;
`endif

    logic ack_lvl, ack_edge, ack_hit;

    toggle_sync u_ack_sync (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .tog_i   (bus.wr_ack),
        .level_o (ack_lvl),
        .edge_o  (ack_edge)
    );

    // Leaving WAIT_ACK on the first difference means a double toggle counts once.
    assign ack_hit = ack_edge | (ack_lvl ^ ack_seen_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        dout_d     = dout_q;
        index_d    = index_q;
        download_d = download_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        error_d    = error_q;
        ack_seen_d = ack_seen_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef IOCTL_STREAMER_CHKSUM_EN
        chksum_d   = chksum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Tracking the ack level while idle keeps stray toggles from counting later.
                ack_seen_d = ack_lvl;
                if (start) begin
                    error_d = 1'b0;
`ifdef IOCTL_STREAMER_CHKSUM_EN
                    chksum_d = 8'd0;
`endif
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        index_d    = index_in;
                        addr_d     = base_addr;
                        remain_d   = length;
                        download_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                if (bus.src_valid) begin
                    dout_d  = bus.src_data;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                ack_seen_d = ack_lvl;
                to_cnt_d   = 16'd0;
                state_d    = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (ack_hit) begin
                    remain_d = remain_q - ADDR_W'(1);
`ifdef IOCTL_STREAMER_CHKSUM_EN
                    chksum_d = chksum_add(chksum_q, dout_q);
`endif
                    if (remain_q == ADDR_W'(1)) begin
                        download_d = 1'b0;
                        done_d     = ~error_q;
                        state_d    = ST_FINISH;
                    end else if (GAP == 0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end else begin
                        gap_cnt_d = 4'd0;
                        state_d   = ST_GAP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    error_d    = 1'b1;
                    download_d = 1'b0;
                    state_d    = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                download_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            dout_q     <= 8'd0;
            index_q    <= 8'd0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ack_seen_q <= 1'b0;
            to_cnt_q   <= 16'd0;
            gap_cnt_q  <= 4'd0;
`ifdef IOCTL_STREAMER_CHKSUM_EN
            chksum_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            dout_q     <= dout_d;
            index_q    <= index_d;
            download_q <= download_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ack_seen_q <= ack_seen_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef IOCTL_STREAMER_CHKSUM_EN
            chksum_q   <= chksum_d;
`endif
        end
    end

    assign bus.src_ready      = (state_q == ST_FETCH);
    assign bus.ioctl_download = download_q;
    assign bus.ioctl_index    = index_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign busy               = (state_q != ST_IDLE);
    assign done               = done_q;
    assign error              = error_q;
`ifdef IOCTL_STREAMER_CHKSUM_EN
    assign chksum             = chksum_q;
`endif
endmodule

// File: tb/tb_ioctl_streamer.sv
// Scoreboard bench for ioctl_streamer: source model, toggle-ack responder and write monitor.
module tb_ioctl_streamer;
    import ioctl_pkg::*;

    localparam int AW = 25;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    index_in = 8'd0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] length = '0;
    logic          busy, done, error;
`ifdef IOCTL_STREAMER_CHKSUM_EN
    logic [7:0]    chksum;
`endif

    ioctl_streamer_if #(.ADDR_W(AW)) bus_if ();

    ioctl_streamer #(.ADDR_W(AW), .GAP(2), .ACK_TO(8)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .index_in  (index_in),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .error     (error)
`ifdef IOCTL_STREAMER_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_total = 0;
    int done_total = 0;
    int wr_cyc_q[$];
    logic [7:0] src_q[$];
    wr_t exp_q[$];
    int accepted = 0;
    int stall_at = -1;
    int stall_len = 0;
    int stall_left = 0;
    int resp_cnt = 0;
    bit resp_en = 1'b1;
    logic [7:0] chk_at_done = 8'd0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic src_refresh();
        bus_if.src_valid = (src_q.size() > 0);
        bus_if.src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    // One clock: source handshake, ack responder, then scoreboard on the write strobe.
    task automatic cycle();
        bit  acc;
        wr_t e;
        acc = bus_if.src_valid && bus_if.src_ready;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (acc) begin
            void'(src_q.pop_front());
            accepted++;
            if (accepted == stall_at) stall_left = stall_len;
        end
        if (stall_left > 0) begin
            bus_if.src_valid = 1'b0;
            stall_left--;
        end else begin
            bus_if.src_valid = (src_q.size() > 0);
        end
        bus_if.src_data = (src_q.size() > 0) ? src_q[0] : 8'h00;

        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) bus_if.wr_ack = ~bus_if.wr_ack;
        end
        if (bus_if.ioctl_wr && resp_en) resp_cnt = 3;

        if (bus_if.ioctl_wr === 1'b1) begin
            wr_total++;
            wr_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", bus_if.ioctl_addr, bus_if.ioctl_dout);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.ioctl_addr !== e.addr || bus_if.ioctl_dout !== e.data) begin
                    n_fail++;
                    $display("FAIL write_data: addr=%h data=%h, required addr=%h data=%h",
                             bus_if.ioctl_addr, bus_if.ioctl_dout, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) begin
            done_total++;
`ifdef IOCTL_STREAMER_CHKSUM_EN
            chk_at_done = chksum;
`endif
        end
    endtask

    task automatic pulse_start(input logic [7:0] idx, input logic [AW-1:0] base, input logic [AW-1:0] len);
        index_in  = idx;
        base_addr = base;
        length    = len;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic run_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            cycle();
        end
        if (!busy) ok = 1'b1;
    endtask

    task automatic load(input logic [AW-1:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(bytes[i]);
            exp_q.push_back('{addr: base + AW'(i), data: bytes[i]});
        end
        src_refresh();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_if.src_valid = 1'b0;
        bus_if.src_data = 8'h00;
        bus_if.wr_ack = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if ({bus_if.ioctl_download, bus_if.ioctl_wr, busy, done, error, bus_if.src_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: dl/wr/busy/done/err/rdy=%b, required 000000",
                     {bus_if.ioctl_download, bus_if.ioctl_wr, busy, done, error, bus_if.src_ready});
        end
        n_checks++;
        if (bus_if.ioctl_addr !== '0 || bus_if.ioctl_index !== 8'd0 || bus_if.ioctl_dout !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h idx=%h dout=%h, required all 0",
                     bus_if.ioctl_addr, bus_if.ioctl_index, bus_if.ioctl_dout);
        end
        reset_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_basic();
        int w0, d0;
        bit ok;
        w0 = wr_total; d0 = done_total;
        wr_cyc_q.delete();
        load(25'h30000, 8'h11, 8'h22, 8'h33, 8'h44, 4);
        pulse_start(IOCTL_IDX_ROM, 25'h30000, 25'd4);
        n_checks++;
        if (bus_if.ioctl_download !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_download_rise: download=%b, required 1", bus_if.ioctl_download);
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            cycle();
            if (bus_if.ioctl_wr === 1'b1) begin
                n_checks++;
                if (bus_if.ioctl_download !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_download_hold: download=%b at write, required 1", bus_if.ioctl_download);
                end
            end
        end
        n_checks++;
        if (!ok || wr_total - w0 != 4 || done_total - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_counts: idle=%0d writes=%0d dones=%0d left=%0d, required 1 4 1 0",
                     ok, wr_total - w0, done_total - d0, exp_q.size());
        end
        n_checks++;
        if (bus_if.ioctl_download !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: download=%b error=%b, required 0 0", bus_if.ioctl_download, error);
        end
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            n_checks++;
            if (wr_cyc_q[i] - wr_cyc_q[i-1] < 7) begin
                n_fail++;
                $display("FAIL basic_spacing: %0d cycles, required at least 7", wr_cyc_q[i] - wr_cyc_q[i-1]);
            end
        end
    endtask

    task automatic test_stall();
        int w0;
        bit ok;
        w0 = wr_total;
        wr_cyc_q.delete();
        accepted = 0; stall_at = 1; stall_len = 10;
        load(25'h100, 8'h01, 8'h02, 8'h03, 8'h04, 4);
        pulse_start(IOCTL_IDX_ROM, 25'h100, 25'd4);
        run_idle(400, ok);
        stall_at = -1;
        n_checks++;
        if (!ok || wr_total - w0 != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_counts: idle=%0d writes=%0d left=%0d, required 1 4 0", ok, wr_total - w0, exp_q.size());
        end
        n_checks++;
        if (wr_cyc_q.size() < 2 || wr_cyc_q[1] - wr_cyc_q[0] <= 10) begin
            n_fail++;
            $display("FAIL stall_gap: write 1->2 spacing %0d, required more than 10",
                     (wr_cyc_q.size() < 2) ? -1 : wr_cyc_q[1] - wr_cyc_q[0]);
        end
    endtask

    task automatic test_timeout();
        int w0, d0, err_cyc;
        bit ok;
        w0 = wr_total; d0 = done_total; err_cyc = -1;
        wr_cyc_q.delete();
        resp_en = 1'b0;
        load(25'h200, 8'h31, 8'h32, 8'h33, 8'h00, 1);
        src_q.push_back(8'h32); src_q.push_back(8'h33);
        pulse_start(IOCTL_IDX_ROM, 25'h200, 25'd3);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            cycle();
            if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
        end
        n_checks++;
        if (!ok || error !== 1'b1 || wr_total - w0 != 1 || done_total - d0 != 0 || bus_if.ioctl_download !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_end: idle=%0d err=%b writes=%0d dones=%0d dl=%b, required 1 1 1 0 0",
                     ok, error, wr_total - w0, done_total - d0, bus_if.ioctl_download);
        end
        n_checks++;
        if (wr_cyc_q.size() != 1 || err_cyc - wr_cyc_q[0] < 8 || err_cyc - wr_cyc_q[0] > 12) begin
            n_fail++;
            $display("FAIL timeout_delay: error %0d cycles after write, required 8..12",
                     (wr_cyc_q.size() == 0) ? -1 : err_cyc - wr_cyc_q[0]);
        end
        src_q.delete();
        resp_en = 1'b1;
        d0 = done_total;
        load(25'h300, 8'h5A, 8'h00, 8'h00, 8'h00, 1);
        pulse_start(IOCTL_IDX_ROM, 25'h300, 25'd1);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: error=%b after new start, required 0", error);
        end
        run_idle(100, ok);
        n_checks++;
        if (!ok || done_total - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_recover: idle=%0d dones=%0d left=%0d, required 1 1 0", ok, done_total - d0, exp_q.size());
        end
    endtask

    task automatic test_zero_and_busy();
        int w0, d0;
        bit ok;
        d0 = done_total;
        pulse_start(IOCTL_IDX_ROM, 25'h500, 25'd0);
        n_checks++;
        if (done !== 1'b1 || bus_if.ioctl_download !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: done=%b dl=%b busy=%b, required 1 0 0", done, bus_if.ioctl_download, busy);
        end
        cycle();
        n_checks++;
        if (done !== 1'b0 || done_total - d0 != 1) begin
            n_fail++;
            $display("FAIL zero_len_pulse: done=%b count=%0d, required 0 1", done, done_total - d0);
        end
        w0 = wr_total; d0 = done_total;
        load(25'h600, 8'h60, 8'h61, 8'h62, 8'h00, 3);
        for (int i = 0; i < 9; i++) src_q.push_back(8'h70 + 8'(i));
        pulse_start(IOCTL_IDX_MOD, 25'h600, 25'd3);
        for (int i = 0; i < 50; i++) begin
            if (wr_total != w0) break;
            cycle();
        end
        pulse_start(IOCTL_IDX_DIP, 25'h700, 25'd9);
        run_idle(300, ok);
        n_checks++;
        if (!ok || wr_total - w0 != 3 || done_total - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start: idle=%0d writes=%0d dones=%0d left=%0d, required 1 3 1 0",
                     ok, wr_total - w0, done_total - d0, exp_q.size());
        end
        n_checks++;
        if (bus_if.ioctl_index !== IOCTL_IDX_MOD) begin
            n_fail++;
            $display("FAIL busy_index: index=%h, required %h", bus_if.ioctl_index, IOCTL_IDX_MOD);
        end
        src_q.delete();
        src_refresh();
    endtask

    task automatic test_wrap();
        int w0;
        bit ok;
        w0 = wr_total;
        src_q.push_back(8'hC1); src_q.push_back(8'hC2);
        exp_q.push_back('{addr: 25'h1FFFFFF, data: 8'hC1});
        exp_q.push_back('{addr: 25'h0000000, data: 8'hC2});
        src_refresh();
        pulse_start(IOCTL_IDX_ROM, 25'h1FFFFFF, 25'd2);
        run_idle(200, ok);
        n_checks++;
        if (!ok || wr_total - w0 != 2 || exp_q.size() != 0 || bus_if.ioctl_addr !== '0) begin
            n_fail++;
            $display("FAIL wrap: idle=%0d writes=%0d left=%0d addr=%h, required 1 2 0 0000000",
                     ok, wr_total - w0, exp_q.size(), bus_if.ioctl_addr);
        end
    endtask

    task automatic test_async_reset();
        int w0, d0;
        w0 = wr_total;
        load(25'h400, 8'hAA, 8'hBB, 8'h00, 8'h00, 2);
        pulse_start(IOCTL_IDX_ROM, 25'h400, 25'd2);
        for (int i = 0; i < 50; i++) begin
            if (wr_total != w0) break;
            cycle();
        end
        cycle();
        d0 = done_total;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.ioctl_download, bus_if.ioctl_wr, busy, done} !== 4'b0 || bus_if.ioctl_addr !== '0) begin
            n_fail++;
            $display("FAIL async_reset: dl/wr/busy/done=%b addr=%h, required 0000 0",
                     {bus_if.ioctl_download, bus_if.ioctl_wr, busy, done}, bus_if.ioctl_addr);
        end
        cycle();
        cycle();
        reset_n = 1'b1;
        exp_q.delete();
        src_q.delete();
        resp_cnt = 0;
        src_refresh();
        repeat (20) cycle();
        n_checks++;
        if (done_total != d0 || bus_if.ioctl_download !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_after: dones=%0d dl=%b, required 0 0", done_total - d0, bus_if.ioctl_download);
        end
    endtask

`ifdef IOCTL_STREAMER_CHKSUM_EN
    task automatic test_chksum();
        bit ok;
        chk_at_done = 8'h00;
        load(25'h800, 8'hFF, 8'h02, 8'h10, 8'h00, 3);
        pulse_start(IOCTL_IDX_ROM, 25'h800, 25'd3);
        run_idle(300, ok);
        n_checks++;
        if (!ok || chk_at_done !== 8'h11) begin
            n_fail++;
            $display("FAIL chksum: idle=%0d chksum=%h, required 1 11", ok, chk_at_done);
        end
    endtask
`endif

    initial begin
        bus_if.src_valid = 1'b0;
        bus_if.src_data  = 8'h00;
        bus_if.wr_ack    = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_zero_and_busy();
        test_wrap();
`ifdef IOCTL_STREAMER_CHKSUM_EN
        test_chksum();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ioctl_streamer.md
Name: ioctl_streamer

Overview:
- Transmit end of the ioctl download interface.
- Pulls bytes from a byte-wide valid/ready source and presents them as a download stream: `ioctl_download`, one-cycle `ioctl_wr` pulses, incrementing `ioctl_addr`, `ioctl_dout`, `ioctl_index`.
- Paces each write on a toggle-style acknowledge returned by the SDRAM loader port, so the core-side download controller never overruns SDRAM.
- Used for in-core image copies (e.g. restoring hiscore/NVRAM images) and as the bench stimulus source for ROM-load paths.

Parameters:
- ADDR_W, 25, width of ioctl_addr and length.
- GAP, 2, idle cycles after each acknowledged write before the next byte is fetched (0..15).
- ACK_TO, 255, cycles to wait for an acknowledge toggle before aborting (1..65535).

Ports:
- clk_sys  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a transfer when idle, ignored when busy.
- index_in  in  8  index value presented on ioctl_index for the transfer.
- base_addr  in  ADDR_W  first ioctl_addr of the transfer.
- length  in  ADDR_W  byte count.
- src_valid  in  1  source byte available.
- src_data  in  8  source byte.
- src_ready  out  1  byte accepted this cycle when src_valid & src_ready.
- wr_ack  in  1  toggle from the SDRAM loader port; each change acknowledges one write.
- ioctl_download  out  1  high for the whole transfer.
- ioctl_index  out  8  latched index_in.
- ioctl_wr  out  1  one-cycle write strobe.
- ioctl_addr  out  ADDR_W  byte address.
- ioctl_dout  out  8  byte data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky ack timeout; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0 (ioctl_addr 0, ioctl_index 0, error 0); state IDLE; ack_seen captures wr_ack on the first clock after reset release.
- States: IDLE, FETCH, WRITE, WAIT_ACK, GAP, FINISH.
- IDLE
  - On start with length == 0: pulse done next cycle; ioctl_download never rises.
  - On start with length != 0: latch index_in, base_addr into ioctl_addr, remaining = length; clear error; set ioctl_download = 1; go to FETCH.
- FETCH
  - src_ready = 1. On src_valid: register src_data into ioctl_dout, go to WRITE.
  - src_ready is combinationally 1 only in FETCH, so exactly one byte is taken per write.
- WRITE
  - ioctl_wr = 1 for exactly one cycle.
  - ioctl_addr and ioctl_dout are stable from the WRITE cycle until the next FETCH accept.
  - Sample ack_seen = wr_ack; go to WAIT_ACK with the timeout counter cleared.
- WAIT_ACK
  - wr_ack is double-registered internally before comparison.
  - Synced wr_ack != ack_seen → decrement remaining. If remaining becomes 0, go to FINISH; else go to GAP.
  - Counter reaches ACK_TO → error = 1, go to FINISH without done.
  - If the toggle changes more than once during the wait, only one acknowledge is counted.
- GAP
  - Count GAP cycles with outputs held, then increment ioctl_addr by 1 (modulo 2^ADDR_W; wrap is legal) and go to FETCH.
  - GAP = 0 goes straight to FETCH with the increment.
- FINISH
  - ioctl_download = 0 this cycle.
  - done = 1 for one cycle only if error == 0.
  - Return to IDLE. ioctl_addr keeps its last written value.
- Minimum spacing between consecutive ioctl_wr pulses is 5 + GAP cycles (2-cycle sync included); it is never less than 2.
- Start while busy is ignored; parameters latched at the accepted start are unaffected.
- Asynchronous reset mid-transfer drops ioctl_download and ioctl_wr immediately; no done pulse is issued.

Optional Feature:
- Macro: IOCTL_STREAMER_CHKSUM_EN.
- When defined: adds output `chksum` [7:0]. Cleared at an accepted start; chksum += byte modulo 256 at each acknowledged write; valid when done pulses and held until the next start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package ioctl_pkg holds:
  - the state enum (IDLE, FETCH, WRITE, WAIT_ACK, GAP, FINISH);
  - localparams IOCTL_IDX_ROM = 8'd0, IOCTL_IDX_MOD = 8'd1, IOCTL_IDX_DIP = 8'd254;
  - the default ADDR_W.
- Sub-module toggle_sync: 2-flop synchronizer plus edge detector for wr_ack, reusable by other req/ack toggle users.

Test Plan:
- Basic stream: start, index_in=0, base_addr=0x30000, length=4, source 11,22,33,44 always valid, responder toggles wr_ack 3 cycles after each ioctl_wr → four writes at 0x30000..0x30003 with those bytes; done once; ioctl_download high from the cycle after start until FINISH.
- Source stall: src_valid low for 10 cycles before byte 2 → no ioctl_wr during the stall; addresses stay contiguous; write count = 4.
- Ack timeout: ACK_TO=8, responder never toggles → error=1 about 10 cycles after the first ioctl_wr; ioctl_download falls; no done; a new start clears error.
- Zero length and busy start: length=0 → done the next cycle, ioctl_download stays 0. During a length-3 transfer, pulse start with length=9 → exactly 3 writes.
- Wrap and reset: ADDR_W=25, base_addr=0x1FFFFFF, length=2 → writes at 0x1FFFFFF then 0x0000000. Assert reset_n=0 in WAIT_ACK → outputs 0 the same cycle; no done.
- Checksum (macro defined): bytes 0xFF,0x02,0x10 → chksum = 0x11 when done pulses.
